// File: rtl/cache_pkg.sv
// Shared constants and types for the cache refill datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cache_pkg;

    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 8;
    localparam int LINE_W         = WORD_W * WORDS_PER_LINE;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } deser_state_t;

    typedef logic [LINE_W-1:0] line_t;

endpackage

// File: rtl/deserializer.sv
// Collects WORDS_PER_LINE memory beats into one cache line (beat 0 in the low word).
// Latency: line_valid rises 1 clk after the handshake of the last beat.
// Backpressure: word_ready drops while a line is held or abort is high; the line is held until line_ready.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   word_in/word_valid/word_ready   memory-side beat handshake
//   abort                      synchronous discard of the partial or held line
//   line_out/line_valid/line_ready  cache-side line handshake
//   beat_cnt                   beats captured in the current line, 0..WORDS_PER_LINE
module deserializer #(
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [WORD_W-1:0]                   word_in,
    input  logic                                word_valid,
    output logic                                word_ready,
    input  logic                                abort,
    output logic [WORD_W*WORDS_PER_LINE-1:0]    line_out,
    output logic                                line_valid,
    input  logic                                line_ready,
    output logic [$clog2(WORDS_PER_LINE):0]     beat_cnt
);
    import cache_pkg::*;

    localparam int LINE_W = WORD_W * WORDS_PER_LINE;
    localparam int IDX_W  = $clog2(WORDS_PER_LINE);
    localparam int CNT_W  = IDX_W + 1;

    deser_state_t             state_q;
    deser_state_t             state_d;
    logic [CNT_W-1:0]         cnt_q;
    logic [LINE_W-1:0]        line_q;
    logic                     beat_hs;
    logic                     last_beat;
    logic [IDX_W-1:0]         wr_idx;

    // The counter has one extra bit so it can read WORDS_PER_LINE while full;
    // only the low bits address the line.
    assign wr_idx    = cnt_q[IDX_W-1:0];
    assign last_beat = (cnt_q == CNT_W'(WORDS_PER_LINE - 1));

    always_comb begin
        word_ready = (state_q == FILL) && !abort;
        beat_hs    = word_valid && word_ready;
        state_d    = state_q;
        if (abort) begin
            state_d = FILL;
        end else if (state_q == FILL) begin
            if (beat_hs && last_beat) begin
                state_d = FULL;
            end
        end else if (line_ready) begin
            state_d = FILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            if (abort) begin
                cnt_q <= '0;
            end else if (beat_hs) begin
                line_q[wr_idx*WORD_W +: WORD_W] <= word_in;
                cnt_q                           <= cnt_q + CNT_W'(1);
            end else if ((state_q == FULL) && line_ready) begin
                cnt_q <= '0;
            end
        end
    end

    // Upper words are not cleared between lines; they are stale until overwritten.
    assign line_out   = line_q;
    assign line_valid = (state_q == FULL);
    assign beat_cnt   = cnt_q;

endmodule

// File: tb/tb_deserializer.sv
// Randomized and directed bench for deserializer against a queue-based line model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_deserializer;

    localparam int WW  = 32;
    localparam int WPL = 8;
    localparam int LW  = WW * WPL;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [WW-1:0]  word_in;
    logic           word_valid;
    logic           word_ready;
    logic           abort;
    logic [LW-1:0]  line_out;
    logic           line_valid;
    logic           line_ready;
    logic [3:0]     beat_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // Words accepted into the line currently being built or held.
    logic [WW-1:0] mq[$];

    deserializer #(.WORD_W(WW), .WORDS_PER_LINE(WPL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .abort      (abort),
        .line_out   (line_out),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .beat_cnt   (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] pack_line(input logic [WW-1:0] base);
        logic [LW-1:0] l;
        l = '0;
        for (int i = 0; i < WPL; i++) l[i*WW +: WW] = base + WW'(i);
        return l;
    endfunction

    function automatic logic [LW-1:0] pack_q();
        logic [LW-1:0] l;
        l = '0;
        for (int i = 0; i < mq.size(); i++) l[i*WW +: WW] = mq[i];
        return l;
    endfunction

    // One clock: drive inputs after the falling edge, check outputs before the
    // rising edge, then advance the model by what that edge should do.
    task automatic step(input logic v, input logic [WW-1:0] d, input logic ab, input logic lr);
        bit full;
        @(negedge clk);
        word_valid = v;
        word_in    = d;
        abort      = ab;
        line_ready = lr;
        #1;
        full = (mq.size() == WPL);
        check("word_ready", LW'(word_ready), LW'(!full && !ab));
        check("beat_cnt",   LW'(beat_cnt),   LW'(mq.size()));
        check("line_valid", LW'(line_valid), LW'(full));
        if (full) check("line_out", line_out, pack_q());
        if (ab)              mq.delete();
        else if (!full && v) mq.push_back(d);
        else if (full && lr) mq.delete();
    endtask

    task automatic beats(input logic [WW-1:0] base, input int n, input logic lr);
        for (int i = 0; i < n; i++) step(1'b1, base + WW'(i), 1'b0, lr);
    endtask

    initial begin
        rst_n      = 1'b0;
        word_in    = '0;
        word_valid = 1'b0;
        abort      = 1'b0;
        line_ready = 1'b0;
        #12;
        check("rst_line_out",   line_out,          '0);
        check("rst_line_valid", LW'(line_valid),   '0);
        check("rst_beat_cnt",   LW'(beat_cnt),     '0);
        rst_n = 1'b1;

        // Back-to-back line with the consumer always ready.
        beats(32'h1000_0000, WPL, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("b2b_valid", LW'(line_valid), LW'(1));
        check("b2b_line",  line_out, pack_line(32'h1000_0000));
        step(1'b0, '0, 1'b0, 1'b0);

        // word_valid on every other cycle; same line expected.
        for (int i = 0; i < 2 * WPL; i++)
            step(i[0], 32'h1000_0000 + WW'(i / 2), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("toggle_line", line_out, pack_line(32'h1000_0000));

        // Held line with stray beats offered and no consumer.
        for (int i = 0; i < 5; i++) step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("hold_line", line_out, pack_line(32'h1000_0000));
        step(1'b0, '0, 1'b0, 1'b1);

        // Abort a partial line, then build a fresh one.
        beats(32'hB0, 3, 1'b0);
        step(1'b1, 32'hBAD0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("abort_cnt", LW'(beat_cnt), '0);
        beats(32'hA0, WPL, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("abort_line", line_out, pack_line(32'hA0));
        step(1'b0, '0, 1'b0, 1'b1);

        // Abort together with line_ready while full drops the line.
        beats(32'h5000_0000, WPL, 1'b0);
        step(1'b1, 32'h7777, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        check("abort_full_valid", LW'(line_valid), '0);

        // Asynchronous reset in the middle of a clock after 5 beats.
        beats(32'hE0, 5, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_line_out",   line_out,        '0);
        check("arst_line_valid", LW'(line_valid), '0);
        check("arst_beat_cnt",   LW'(beat_cnt),   '0);
        #1;
        rst_n = 1'b1;
        mq.delete();
        beats(32'hC0, WPL, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("arst_new_line", line_out, pack_line(32'hC0));
        step(1'b0, '0, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
